// File: rtl/sipo_piso_pkg.sv
// Shared definitions for the PISO/SIPO serial shift link.
package sipo_piso_pkg;

  localparam int unsigned DefDSize = 4;

  typedef enum logic {
    StEmpty = 1'b0,
    StFull  = 1'b1
  } hold_state_e;

  function automatic int unsigned cnt_width(input int unsigned d_size);
    return $clog2(d_size);
  endfunction

endpackage

// File: rtl/sipo_out_hold.sv
// Valid/ready output holding register; flags a completed word dropped while full.
module sipo_out_hold
  import sipo_piso_pkg::*;
#(
  parameter int unsigned D_SIZE = DefDSize
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [D_SIZE-1:0] word,
  input  logic              ready,
  output logic [D_SIZE-1:0] data,
  output logic              valid,
  output logic              overrun_set
);

  hold_state_e       state_q, state_d;
  logic [D_SIZE-1:0] data_q, data_d;

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    overrun_set = 1'b0;
    unique case (state_q)
      StEmpty: begin
        if (load) begin
          state_d = StFull;
          data_d  = word;
        end
      end
      StFull: begin
        if (load) begin
          // Simultaneous accept frees the slot for the new word.
          if (ready) data_d = word;
          else       overrun_set = 1'b1;
        end else if (ready) begin
          state_d = StEmpty;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEmpty;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  assign data  = data_q;
  assign valid = (state_q == StFull);

endmodule

// File: rtl/sipo_shift_rx.sv
// Serial-in parallel-out receiver: assembles D_SIZE-bit words from a serial stream
// and presents them through a valid/ready holding register.
module sipo_shift_rx
  import sipo_piso_pkg::*;
#(
  parameter int unsigned D_SIZE    = DefDSize,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_in,
  input  logic              serial_in,
  input  logic              sync_in,
  output logic [D_SIZE-1:0] parallel_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              overrun
);

  localparam int unsigned    CntW = cnt_width(D_SIZE);
  localparam logic [CntW-1:0] Last = CntW'(D_SIZE - 1);

  logic [D_SIZE-1:0] sh_q, sh_d, sh_base, sh_shifted;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              busy_q;
  logic              overrun_q, overrun_d;
  logic              word_done;
  logic              overrun_set;

  // A sync edge shifts into a cleared register so the sampled bit starts a new word.
  assign sh_base = sync_in ? '0 : sh_q;

  if (LSB_FIRST) begin : g_lsb_first
    assign sh_shifted = {serial_in, sh_base[D_SIZE-1:1]};
  end else begin : g_msb_first
    assign sh_shifted = {sh_base[D_SIZE-2:0], serial_in};
  end

  assign word_done = en_in && !sync_in && (cnt_q == Last);

  always_comb begin
    sh_d      = sh_q;
    cnt_d     = cnt_q;
    overrun_d = overrun_q | overrun_set;
    if (sync_in) begin
      sh_d      = en_in ? sh_shifted : '0;
      cnt_d     = en_in ? CntW'(1) : '0;
      overrun_d = 1'b0;
    end else if (en_in) begin
      sh_d  = sh_shifted;
      cnt_d = (cnt_q == Last) ? '0 : cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q      <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      sh_q      <= sh_d;
      cnt_q     <= cnt_d;
      busy_q    <= (cnt_d != '0);
      overrun_q <= overrun_d;
    end
  end

  sipo_out_hold #(
    .D_SIZE (D_SIZE)
  ) u_out_hold (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (word_done),
    .word        (sh_d),
    .ready       (out_ready),
    .data        (parallel_out),
    .valid       (out_valid),
    .overrun_set (overrun_set)
  );

  assign busy    = busy_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_sipo_shift_rx.sv
// Directed bench for sipo_shift_rx: LSB-first and MSB-first instances share stimulus.
module tb_sipo_shift_rx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en_in = 1'b0;
  logic       serial_in = 1'b0;
  logic       sync_in = 1'b0;
  logic       out_ready = 1'b0;
  logic [3:0] l_data, m_data;
  logic       l_valid, m_valid, l_busy, m_busy, l_ovr, m_ovr;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sipo_shift_rx #(.D_SIZE(4), .LSB_FIRST(1'b1)) dut_lsb (
    .clk          (clk),
    .rst_n        (rst_n),
    .en_in        (en_in),
    .serial_in    (serial_in),
    .sync_in      (sync_in),
    .parallel_out (l_data),
    .out_valid    (l_valid),
    .out_ready    (out_ready),
    .busy         (l_busy),
    .overrun      (l_ovr)
  );

  sipo_shift_rx #(.D_SIZE(4), .LSB_FIRST(1'b0)) dut_msb (
    .clk          (clk),
    .rst_n        (rst_n),
    .en_in        (en_in),
    .serial_in    (serial_in),
    .sync_in      (sync_in),
    .parallel_out (m_data),
    .out_valid    (m_valid),
    .out_ready    (out_ready),
    .busy         (m_busy),
    .overrun      (m_ovr)
  );

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step(input logic en, input logic b, input logic sy, input logic rdy);
    en_in = en; serial_in = b; sync_in = sy; out_ready = rdy;
    @(posedge clk); #1;
    en_in = 1'b0; sync_in = 1'b0; out_ready = 1'b0;
  endtask

  task automatic send_word(input logic [3:0] bits, input logic rdy_last);
    // bits[3] is sent first
    for (int i = 3; i >= 0; i--) step(1'b1, bits[i], 1'b0, (i == 0) ? rdy_last : 1'b0);
  endtask

  task automatic drain();
    step(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++;
    if ({l_data, l_valid, l_busy, l_ovr} !== 7'h0) begin
      failures++;
      $display("FAIL reset_lsb: got data=%h v=%b b=%b o=%b want all 0", l_data, l_valid, l_busy,
               l_ovr);
    end
    checks++;
    if ({m_data, m_valid, m_busy, m_ovr} !== 7'h0) begin
      failures++;
      $display("FAIL reset_msb: got data=%h v=%b b=%b o=%b want all 0", m_data, m_valid, m_busy,
               m_ovr);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_bit_order();
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (l_valid !== 1'b0 || l_busy !== 1'b1) begin
      failures++;
      $display("FAIL order_partial: got v=%b busy=%b want v=0 busy=1", l_valid, l_busy);
    end
    step(1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (l_data !== 4'hD || l_valid !== 1'b1 || l_busy !== 1'b0) begin
      failures++;
      $display("FAIL order_lsb: got data=%h v=%b busy=%b want D 1 0", l_data, l_valid, l_busy);
    end
    checks++;
    if (m_data !== 4'hB || m_valid !== 1'b1) begin
      failures++;
      $display("FAIL order_msb: got data=%h v=%b want B 1", m_data, m_valid);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (l_data !== 4'hD || l_valid !== 1'b1) begin
      failures++;
      $display("FAIL order_hold: got data=%h v=%b want D 1", l_data, l_valid);
    end
    drain();
    checks++;
    if (l_valid !== 1'b0 || m_valid !== 1'b0) begin
      failures++;
      $display("FAIL order_accept: got v=%b/%b want 0/0", l_valid, m_valid);
    end
  endtask

  task automatic test_gaps();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (l_busy !== 1'b1 || l_valid !== 1'b0) begin
      failures++;
      $display("FAIL gap_idle: got busy=%b v=%b want 1 0", l_busy, l_valid);
    end
    step(1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (l_valid !== 1'b0) begin
      failures++;
      $display("FAIL gap_early: got v=%b want 0", l_valid);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (l_data !== 4'h6 || l_valid !== 1'b1 || l_busy !== 1'b0) begin
      failures++;
      $display("FAIL gap_word: got data=%h v=%b busy=%b want 6 1 0", l_data, l_valid, l_busy);
    end
    drain();
  endtask

  task automatic test_overrun();
    send_word(4'b0101, 1'b0);
    checks++;
    if (l_data !== 4'hA || l_valid !== 1'b1 || l_ovr !== 1'b0) begin
      failures++;
      $display("FAIL ovr_first: got data=%h v=%b o=%b want A 1 0", l_data, l_valid, l_ovr);
    end
    send_word(4'b1010, 1'b0);
    checks++;
    if (l_data !== 4'hA || l_valid !== 1'b1 || l_ovr !== 1'b1) begin
      failures++;
      $display("FAIL ovr_drop: got data=%h v=%b o=%b want A 1 1", l_data, l_valid, l_ovr);
    end
    drain();
    checks++;
    if (l_valid !== 1'b0 || l_ovr !== 1'b1) begin
      failures++;
      $display("FAIL ovr_sticky: got v=%b o=%b want 0 1", l_valid, l_ovr);
    end
  endtask

  task automatic test_sync();
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    checks++;
    if (l_ovr !== 1'b0 || l_busy !== 1'b1 || l_valid !== 1'b0) begin
      failures++;
      $display("FAIL sync_edge: got o=%b busy=%b v=%b want 0 1 0", l_ovr, l_busy, l_valid);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (l_valid !== 1'b0) begin
      failures++;
      $display("FAIL sync_early: got v=%b want 0", l_valid);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (l_data !== 4'h1 || l_valid !== 1'b1 || m_data !== 4'h8) begin
      failures++;
      $display("FAIL sync_word: got lsb=%h v=%b msb=%h want 1 1 8", l_data, l_valid, m_data);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    send_word(4'b0101, 1'b0);
    send_word(4'b1010, 1'b1);
    checks++;
    if (l_data !== 4'h5 || l_valid !== 1'b1 || l_ovr !== 1'b0) begin
      failures++;
      $display("FAIL b2b_word: got data=%h v=%b o=%b want 5 1 0", l_data, l_valid, l_ovr);
    end
    drain();
    drain();
    checks++;
    if (l_valid !== 1'b0 || l_data !== 4'h5) begin
      failures++;
      $display("FAIL b2b_empty_ready: got v=%b data=%h want 0 5", l_valid, l_data);
    end
  endtask

  task automatic test_async_reset();
    send_word(4'b0101, 1'b0);
    send_word(4'b1010, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (l_valid !== 1'b1 || l_ovr !== 1'b1 || l_busy !== 1'b1) begin
      failures++;
      $display("FAIL arst_setup: got v=%b o=%b busy=%b want 1 1 1", l_valid, l_ovr, l_busy);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({l_data, l_valid, l_busy, l_ovr} !== 7'h0) begin
      failures++;
      $display("FAIL arst_clear: got data=%h v=%b b=%b o=%b want all 0", l_data, l_valid,
               l_busy, l_ovr);
    end
    #1 rst_n = 1'b1;
    send_word(4'b0011, 1'b0);
    checks++;
    if (l_data !== 4'hC || l_valid !== 1'b1 || l_busy !== 1'b0 || l_ovr !== 1'b0) begin
      failures++;
      $display("FAIL arst_word: got data=%h v=%b b=%b o=%b want C 1 0 0", l_data, l_valid,
               l_busy, l_ovr);
    end
  endtask

  initial begin
    test_reset();
    test_bit_order();
    test_gaps();
    test_overrun();
    test_sync();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
